// File: rtl/processador_pkg.sv
// Shared definitions for the parametrised multicycle processor.
// This file holds the opcodes, the step encodings, the bus sources and the flag bit positions.
package processador_pkg;

   localparam logic [3:0] OP_MV   = 4'h0;
   localparam logic [3:0] OP_MVI  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_SLT  = 4'h7;
   localparam logic [3:0] OP_SLL  = 4'h8;
   localparam logic [3:0] OP_SRL  = 4'h9;
   localparam logic [3:0] OP_MVNZ = 4'hA;

   // Bit positions inside the {C,N,Z} status vector.
   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_C = 2;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } tstep_t;

   typedef enum logic [2:0] {
      BUS_ZERO,
      BUS_RX,
      BUS_RY,
      BUS_DIN,
      BUS_G
   } bus_sel_t;

   function automatic logic is_alu_op(input logic [3:0] opc);
      return (opc >= OP_ADD) && (opc <= OP_SRL);
   endfunction

endpackage

// File: rtl/ula_param.sv
// Combinational ALU for the multicycle processor.
// It produces the result and the carry/borrow flag for the add..srl opcodes.
module ula_param
   import processador_pkg::*;
#(
   parameter int unsigned DATA_W = 16
)
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        opc,
   output logic [DATA_W-1:0] res,
   output logic              c
);

   localparam int unsigned SH_W = $clog2(DATA_W);

   logic [SH_W-1:0] sh_amt;
   logic [DATA_W:0] sum;

   // The shift amount is masked to the low log2(DATA_W) bits of b.
   assign sh_amt = b[SH_W-1:0];
   assign sum    = {1'b0, a} + {1'b0, b};

   always_comb begin
      res = '0;
      c   = 1'b0;
      case (opc)
         OP_ADD: begin
            res = sum[DATA_W-1:0];
            c   = sum[DATA_W];
         end
         OP_SUB: begin
            res = a - b;
            c   = (a < b);
         end
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_XOR:  res = a ^ b;
         OP_SLT:  res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLL:  res = a << sh_amt;
         OP_SRL:  res = a >> sh_amt;
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/processador_multiciclo_param.sv
// Parametrised multicycle processor that sequences each instruction over steps T0..T3 on a shared bus.
// It provides ALU status flags, an illegal-opcode indication and a debug register read port.
module processador_multiciclo_param
   import processador_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned NREGS  = 8,
   parameter int unsigned OPC_W  = 4,
   localparam int unsigned REG_W = $clog2(NREGS)
)
(
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Run,
   input  logic [DATA_W-1:0] DIN,
   output logic              Done,
   output logic              Busy,
   output logic              Illegal,
   output logic [2:0]        Flags,
   output logic [DATA_W-1:0] BusWires,
   input  logic [REG_W-1:0]  DbgSel,
   output logic [DATA_W-1:0] DbgData
);

   localparam int unsigned IR_W = OPC_W + 2*REG_W;

   tstep_t            tstep, tstep_nxt;
   bus_sel_t          bus_sel;
   logic [IR_W-1:0]   ir;
   logic [DATA_W-1:0] regs [NREGS];
   logic [DATA_W-1:0] a_reg, g_reg;
   logic [2:0]        flags_q;

   logic [OPC_W-1:0]  opc;
   logic [3:0]        opc4;
   logic [REG_W-1:0]  rx, ry;
   logic              legal;

   logic              ir_ld, a_ld, g_ld, rx_wr;
   logic [DATA_W-1:0] alu_res;
   logic              alu_c;

   assign opc   = ir[IR_W-1 -: OPC_W];
   assign opc4  = opc[3:0];
   assign rx    = ir[2*REG_W-1 -: REG_W];
   assign ry    = ir[REG_W-1:0];
   // Opcodes above the low nibble are always undefined when OPC_W is wider than 4.
   assign legal = ((opc >> 4) == '0) && (opc4 <= OP_MVNZ);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) tstep <= T0;
      else         tstep <= tstep_nxt;
   end

   always_comb begin
      tstep_nxt = tstep;
      bus_sel   = BUS_ZERO;
      ir_ld     = 1'b0;
      a_ld      = 1'b0;
      g_ld      = 1'b0;
      rx_wr     = 1'b0;
      Done      = 1'b0;
      Illegal   = 1'b0;
      case (tstep)
         T0: begin
            if (Run) begin
               ir_ld     = 1'b1;
               tstep_nxt = T1;
            end
         end
         T1: begin
            if (!legal) begin
               Done      = 1'b1;
               Illegal   = 1'b1;
               tstep_nxt = T0;
            end else if (is_alu_op(opc4)) begin
               bus_sel   = BUS_RX;
               a_ld      = 1'b1;
               tstep_nxt = T2;
            end else begin
               bus_sel   = (opc4 == OP_MVI) ? BUS_DIN : BUS_RY;
               rx_wr     = (opc4 != OP_MVNZ) || (g_reg != '0);
               Done      = 1'b1;
               tstep_nxt = T0;
            end
         end
         T2: begin
            bus_sel   = BUS_RY;
            g_ld      = 1'b1;
            tstep_nxt = T3;
         end
         T3: begin
            bus_sel   = BUS_G;
            rx_wr     = 1'b1;
            Done      = 1'b1;
            tstep_nxt = T0;
         end
         default: tstep_nxt = T0;
      endcase
   end

   assign Busy = (tstep != T0);

   always_comb begin
      BusWires = '0;
      case (bus_sel)
         BUS_RX:  BusWires = regs[rx];
         BUS_RY:  BusWires = regs[ry];
         BUS_DIN: BusWires = DIN;
         BUS_G:   BusWires = g_reg;
         default: BusWires = '0;
      endcase
   end

   ula_param #(.DATA_W(DATA_W)) u_ula (
      .a   (a_reg),
      .b   (BusWires),
      .opc (opc4),
      .res (alu_res),
      .c   (alu_c)
   );

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         ir      <= '0;
         a_reg   <= '0;
         g_reg   <= '0;
         flags_q <= '0;
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         if (ir_ld) ir <= DIN[IR_W-1:0];
         if (a_ld)  a_reg <= BusWires;
         if (g_ld) begin
            g_reg           <= alu_res;
            flags_q[FLAG_Z] <= (alu_res == '0);
            flags_q[FLAG_N] <= alu_res[DATA_W-1];
            flags_q[FLAG_C] <= alu_c;
         end
         if (rx_wr) regs[rx] <= BusWires;
      end
   end

   assign Flags   = flags_q;
   assign DbgData = regs[DbgSel];

endmodule
